// File: rtl/stack_pkg.sv
// Shared opcodes and sizing helper for the parameterised operand stack.
package stack_pkg;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_REPL    = 3'b011;
    localparam logic [2:0] OP_POPREPL = 3'b100;
    localparam logic [2:0] OP_POP2    = 3'b101;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Spill array below NOS: one synchronous write port, a combinational refill
// window (top entry and the one beneath it) and a combinational pick port.
module stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [WIDTH-1:0] rdata_next_o,
    input  logic [PTR_W-1:0] paddr_i,
    output logic [WIDTH-1:0] pdata_o
);

    localparam int ENTRIES = DEPTH - 2;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(ENTRIES - 1);

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [PTR_W-1:0] raddr_next;

    // NOTE: storage has no reset; the parent's depth masking hides stale entries.
    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i <= LAST) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign raddr_next   = raddr_i - PTR_W'(1);
    assign rdata_o      = (raddr_i <= LAST) ? mem_q[raddr_i] : '0;
    assign rdata_next_o = (raddr_next <= LAST) ? mem_q[raddr_next] : '0;
    assign pdata_o      = (paddr_i <= LAST) ? mem_q[paddr_i] : '0;

endmodule

// File: rtl/param_stack.sv
// Operand stack with TOS/NOS held in registers, spill array below them,
// registered pick read and sticky error tracking.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             c_CLOCK,
    input  logic             f_RESET,
    input  logic [2:0]       i_OP,
    input  logic [WIDTH-1:0] i_DATA,
    input  logic [PTR_W-1:0] i_PICK,
    output logic [WIDTH-1:0] o_OP1,
    output logic [WIDTH-1:0] o_OP2,
    output logic [WIDTH-1:0] o_PICK,
    output logic [PTR_W:0]   o_DEPTH,
    output logic             o_EMPTY,
    output logic             o_FULL,
    output logic             o_OVERFLOW,
    output logic             o_UNDERFLOW,
    output logic             o_ERROR
);

    localparam logic [PTR_W:0] D0   = '0;
    localparam logic [PTR_W:0] D1   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] D2   = (PTR_W+1)'(2);
    localparam logic [PTR_W:0] D3   = (PTR_W+1)'(3);
    localparam logic [PTR_W:0] D4   = (PTR_W+1)'(4);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]   depth_q, depth_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [WIDTH-1:0] pick_q, pick_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             err_q, err_d;

    logic             ram_we;
    logic [PTR_W-1:0] ram_waddr, ram_raddr, ram_paddr;
    logic [WIDTH-1:0] ram_rdata, ram_rdata_next, ram_pdata;
    logic [WIDTH-1:0] elem2, elem3;

    // Array entry k holds stack element (depth-1-k); modular PTR_W-bit
    // arithmetic is exact because DEPTH is a power of two.
    assign ram_waddr = depth_q[PTR_W-1:0] - PTR_W'(2);
    assign ram_raddr = depth_q[PTR_W-1:0] - PTR_W'(3);
    assign ram_paddr = depth_q[PTR_W-1:0] - PTR_W'(1) - i_PICK;

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk_i        (c_CLOCK),
        .we_i         (ram_we),
        .waddr_i      (ram_waddr),
        .wdata_i      (nos_q),
        .raddr_i      (ram_raddr),
        .rdata_o      (ram_rdata),
        .rdata_next_o (ram_rdata_next),
        .paddr_i      (ram_paddr),
        .pdata_o      (ram_pdata)
    );

    assign elem2 = (depth_q >= D3) ? ram_rdata : '0;
    assign elem3 = (depth_q >= D4) ? ram_rdata_next : '0;

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        depth_d = depth_q;
        tos_d   = tos_q;
        nos_d   = nos_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        ram_we  = 1'b0;
        case (i_OP)
            OP_PUSH: begin
                if (depth_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    ram_we  = (depth_q >= D2);
                    nos_d   = tos_q;
                    tos_d   = i_DATA;
                    depth_d = depth_q + D1;
                end
            end
            OP_POP: begin
                if (depth_q == D0) begin
                    udf_d = 1'b1;
                end else begin
                    tos_d   = nos_q;
                    nos_d   = elem2;
                    depth_d = depth_q - D1;
                end
            end
            OP_REPL: begin
                if (depth_q == D0) udf_d = 1'b1;
                else               tos_d = i_DATA;
            end
            OP_POPREPL: begin
                if (depth_q < D2) begin
                    udf_d = 1'b1;
                end else begin
                    tos_d   = i_DATA;
                    nos_d   = elem2;
                    depth_d = depth_q - D1;
                end
            end
            OP_POP2: begin
                if (depth_q < D2) begin
                    udf_d = 1'b1;
                end else begin
                    tos_d   = elem2;
                    nos_d   = elem3;
                    depth_d = depth_q - D2;
                end
            end
            default: ;
        endcase
        err_d = err_q | ovf_d | udf_d;
    end

    // Pick uses the contents before this cycle's operation lands.
    always_comb begin
        pick_d = '0;
        if ({1'b0, i_PICK} < depth_q) begin
            if (i_PICK == '0)                   pick_d = tos_q;
            else if (i_PICK == PTR_W'(1))       pick_d = nos_q;
            else                                pick_d = ram_pdata;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge c_CLOCK) begin
        if (f_RESET) begin
            depth_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            pick_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            pick_q  <= pick_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            err_q   <= err_d;
        end
    end

    assign o_OP1       = tos_q;
    assign o_OP2       = nos_q;
    assign o_PICK      = pick_q;
    assign o_DEPTH     = depth_q;
    assign o_EMPTY     = (depth_q == D0);
    assign o_FULL      = (depth_q == FULL);
    assign o_OVERFLOW  = ovf_q;
    assign o_UNDERFLOW = udf_q;
    assign o_ERROR     = err_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack with default parameters (WIDTH 16, DEPTH 64).
module tb_param_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int PTR_W = 6;

    logic             c_CLOCK = 1'b0;
    logic             f_RESET = 1'b0;
    logic [2:0]       i_OP    = 3'b000;
    logic [WIDTH-1:0] i_DATA  = '0;
    logic [PTR_W-1:0] i_PICK  = '0;
    logic [WIDTH-1:0] o_OP1, o_OP2, o_PICK;
    logic [PTR_W:0]   o_DEPTH;
    logic             o_EMPTY, o_FULL, o_OVERFLOW, o_UNDERFLOW, o_ERROR;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010,
                           REPL = 3'b011, POPREPL = 3'b100, POP2 = 3'b101;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .c_CLOCK     (c_CLOCK),
        .f_RESET     (f_RESET),
        .i_OP        (i_OP),
        .i_DATA      (i_DATA),
        .i_PICK      (i_PICK),
        .o_OP1       (o_OP1),
        .o_OP2       (o_OP2),
        .o_PICK      (o_PICK),
        .o_DEPTH     (o_DEPTH),
        .o_EMPTY     (o_EMPTY),
        .o_FULL      (o_FULL),
        .o_OVERFLOW  (o_OVERFLOW),
        .o_UNDERFLOW (o_UNDERFLOW),
        .o_ERROR     (o_ERROR)
    );

    always #5 c_CLOCK = ~c_CLOCK;

    // Drive at the falling edge, apply on the rising edge, sample 1 ns later.
    task automatic step(input logic [2:0] op, input logic [WIDTH-1:0] data,
                        input logic [PTR_W-1:0] pick);
        @(negedge c_CLOCK);
        i_OP   = op;
        i_DATA = data;
        i_PICK = pick;
        @(posedge c_CLOCK);
        #1;
        i_OP = NOP;
    endtask

    task automatic do_reset();
        @(negedge c_CLOCK);
        f_RESET = 1'b1;
        i_OP    = NOP;
        @(posedge c_CLOCK);
        #1;
        f_RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_DEPTH !== 7'd0) begin errors++; $display("FAIL rst_depth got %0d exp 0", o_DEPTH); end
        checks++; if (o_OP1 !== 16'h0 || o_OP2 !== 16'h0) begin errors++; $display("FAIL rst_ops got %h/%h exp 0/0", o_OP1, o_OP2); end
        checks++; if (o_PICK !== 16'h0) begin errors++; $display("FAIL rst_pick got %h exp 0", o_PICK); end
        checks++; if ({o_EMPTY, o_FULL, o_OVERFLOW, o_UNDERFLOW, o_ERROR} !== 5'b10000)
            begin errors++; $display("FAIL rst_flags got %b exp 10000", {o_EMPTY, o_FULL, o_OVERFLOW, o_UNDERFLOW, o_ERROR}); end
    endtask

    task automatic test_push();
        do_reset();
        step(PUSH, 16'h0011, '0);
        checks++; if (o_OP1 !== 16'h0011 || o_OP2 !== 16'h0000 || o_DEPTH !== 7'd1)
            begin errors++; $display("FAIL push1 got %h/%h/%0d exp 0011/0000/1", o_OP1, o_OP2, o_DEPTH); end
        step(PUSH, 16'h0022, '0);
        step(PUSH, 16'h0033, '0);
        checks++; if (o_OP1 !== 16'h0033 || o_OP2 !== 16'h0022 || o_DEPTH !== 7'd3)
            begin errors++; $display("FAIL push3 got %h/%h/%0d exp 0033/0022/3", o_OP1, o_OP2, o_DEPTH); end
        checks++; if (o_EMPTY !== 1'b0 || o_FULL !== 1'b0) begin errors++; $display("FAIL push_flags got %b%b exp 00", o_EMPTY, o_FULL); end
    endtask

    task automatic test_poprepl_pop2();
        step(POPREPL, 16'h0055, '0);
        checks++; if (o_OP1 !== 16'h0055 || o_OP2 !== 16'h0011 || o_DEPTH !== 7'd2)
            begin errors++; $display("FAIL poprepl got %h/%h/%0d exp 0055/0011/2", o_OP1, o_OP2, o_DEPTH); end
        step(POP2, '0, '0);
        checks++; if (o_OP1 !== 16'h0 || o_OP2 !== 16'h0 || o_DEPTH !== 7'd0 || o_EMPTY !== 1'b1)
            begin errors++; $display("FAIL pop2 got %h/%h/%0d/e%b exp 0/0/0/e1", o_OP1, o_OP2, o_DEPTH, o_EMPTY); end
        checks++; if (o_UNDERFLOW !== 1'b0 || o_ERROR !== 1'b0) begin errors++; $display("FAIL pop2_noerr got %b%b exp 00", o_UNDERFLOW, o_ERROR); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) step(PUSH, WIDTH'(i), '0);
        checks++; if (o_DEPTH !== 7'd64 || o_FULL !== 1'b1 || o_EMPTY !== 1'b0)
            begin errors++; $display("FAIL fill got %0d f%b e%b exp 64 f1 e0", o_DEPTH, o_FULL, o_EMPTY); end
        step(PUSH, 16'hBEEF, '0);
        checks++; if (o_OVERFLOW !== 1'b1 || o_ERROR !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b%b exp 11", o_OVERFLOW, o_ERROR); end
        checks++; if (o_DEPTH !== 7'd64 || o_OP1 !== 16'h0040 || o_OP2 !== 16'h003F)
            begin errors++; $display("FAIL ovf_state got %0d/%h/%h exp 64/0040/003f", o_DEPTH, o_OP1, o_OP2); end
        step(POP, '0, '0);
        checks++; if (o_OVERFLOW !== 1'b0 || o_ERROR !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b%b exp 01", o_OVERFLOW, o_ERROR); end
        checks++; if (o_DEPTH !== 7'd63 || o_OP1 !== 16'h003F || o_OP2 !== 16'h003E)
            begin errors++; $display("FAIL pop_after_ovf got %0d/%h/%h exp 63/003f/003e", o_DEPTH, o_OP1, o_OP2); end
        // Drain through the array and confirm every refill value.
        for (int d = 62; d >= 1; d--) begin
            step(POP, '0, '0);
            checks++;
            if (o_OP1 !== WIDTH'(d) || o_OP2 !== WIDTH'(d - 1) || o_DEPTH !== 7'(d))
                begin errors++; $display("FAIL drain%0d got %h/%h/%0d exp %h/%h/%0d", d, o_OP1, o_OP2, o_DEPTH, WIDTH'(d), WIDTH'(d - 1), d); end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(POP, '0, '0);
        checks++; if (o_UNDERFLOW !== 1'b1 || o_ERROR !== 1'b1 || o_DEPTH !== 7'd0)
            begin errors++; $display("FAIL udf_pop0 got u%b e%b d%0d exp u1 e1 d0", o_UNDERFLOW, o_ERROR, o_DEPTH); end
        step(PUSH, 16'h0077, '0);
        checks++; if (o_UNDERFLOW !== 1'b0 || o_DEPTH !== 7'd1 || o_OP1 !== 16'h0077)
            begin errors++; $display("FAIL udf_recover got u%b d%0d %h exp u0 d1 0077", o_UNDERFLOW, o_DEPTH, o_OP1); end
        step(POP2, '0, '0);
        checks++; if (o_UNDERFLOW !== 1'b1 || o_DEPTH !== 7'd1 || o_OP1 !== 16'h0077)
            begin errors++; $display("FAIL udf_pop2 got u%b d%0d %h exp u1 d1 0077", o_UNDERFLOW, o_DEPTH, o_OP1); end
        step(POPREPL, 16'h0099, '0);
        checks++; if (o_UNDERFLOW !== 1'b1 || o_DEPTH !== 7'd1 || o_OP1 !== 16'h0077)
            begin errors++; $display("FAIL udf_poprepl got u%b d%0d %h exp u1 d1 0077", o_UNDERFLOW, o_DEPTH, o_OP1); end
        step(REPL, 16'h0088, '0);
        checks++; if (o_UNDERFLOW !== 1'b0 || o_ERROR !== 1'b1 || o_OP1 !== 16'h0088 || o_DEPTH !== 7'd1)
            begin errors++; $display("FAIL repl got u%b e%b %h d%0d exp u0 e1 0088 d1", o_UNDERFLOW, o_ERROR, o_OP1, o_DEPTH); end
    endtask

    task automatic test_pick();
        do_reset();
        step(PUSH, 16'h0011, '0);
        step(PUSH, 16'h0022, '0);
        step(PUSH, 16'h0033, '0);
        step(NOP, '0, 6'd3);
        checks++; if (o_PICK !== 16'h0000) begin errors++; $display("FAIL pick3 got %h exp 0000", o_PICK); end
        step(PUSH, 16'h0044, 6'd2);
        checks++; if (o_PICK !== 16'h0011 || o_DEPTH !== 7'd4) begin errors++; $display("FAIL pick2_push got %h d%0d exp 0011 d4", o_PICK, o_DEPTH); end
        step(NOP, '0, 6'd0);
        checks++; if (o_PICK !== 16'h0044) begin errors++; $display("FAIL pick0 got %h exp 0044", o_PICK); end
        step(NOP, '0, 6'd1);
        checks++; if (o_PICK !== 16'h0033) begin errors++; $display("FAIL pick1 got %h exp 0033", o_PICK); end
        step(NOP, '0, 6'd3);
        checks++; if (o_PICK !== 16'h0011) begin errors++; $display("FAIL pick3_d4 got %h exp 0011", o_PICK); end
        step(NOP, '0, 6'd5);
        checks++; if (o_PICK !== 16'h0000) begin errors++; $display("FAIL pick5 got %h exp 0000", o_PICK); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        for (int i = 1; i <= 5; i++) step(PUSH, WIDTH'(16'h0100 + i), 6'd1);
        checks++; if (o_DEPTH !== 7'd5 || o_OP1 !== 16'h0105) begin errors++; $display("FAIL pre_rst got d%0d %h exp d5 0105", o_DEPTH, o_OP1); end
        @(negedge c_CLOCK);
        f_RESET = 1'b1;
        i_OP    = PUSH;
        i_DATA  = 16'hABCD;
        @(posedge c_CLOCK);
        #1;
        f_RESET = 1'b0;
        i_OP    = NOP;
        checks++; if (o_DEPTH !== 7'd0 || o_OP1 !== 16'h0 || o_OP2 !== 16'h0 || o_PICK !== 16'h0)
            begin errors++; $display("FAIL rst_push got d%0d %h/%h/%h exp all 0", o_DEPTH, o_OP1, o_OP2, o_PICK); end
        checks++; if ({o_EMPTY, o_FULL, o_OVERFLOW, o_UNDERFLOW, o_ERROR} !== 5'b10000)
            begin errors++; $display("FAIL rst_push_flags got %b exp 10000", {o_EMPTY, o_FULL, o_OVERFLOW, o_UNDERFLOW, o_ERROR}); end
        step(NOP, '0, '0);
        checks++; if (o_DEPTH !== 7'd0 || o_OP1 !== 16'h0) begin errors++; $display("FAIL rst_discard got d%0d %h exp d0 0", o_DEPTH, o_OP1); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_poprepl_pop2();
        test_overflow();
        test_underflow();
        test_pick();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 64, meaning maximum stack entries; it SHALL be a power of two and at least 4.
REQ-003 The module SHALL have parameter PTR_W, default $clog2(DEPTH), meaning pick-index width in bits.
REQ-004 The module SHALL have port c_CLOCK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port f_RESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port i_OP, input, 3 bits: operation code.
REQ-007 The module SHALL have port i_DATA, input, WIDTH bits: the value for PUSH, REPL and POPREPL.
REQ-008 The module SHALL have port i_PICK, input, PTR_W bits: pick index, where 0 = TOS.
REQ-009 The module SHALL have port o_OP1, output, WIDTH bits: top of stack (TOS).
REQ-010 The module SHALL have port o_OP2, output, WIDTH bits: second element (NOS).
REQ-011 The module SHALL have port o_PICK, output, WIDTH bits: the element at i_PICK, registered.
REQ-012 The module SHALL have port o_DEPTH, output, PTR_W+1 bits: current entry count, 0..DEPTH.
REQ-013 The module SHALL have ports o_EMPTY and o_FULL, outputs, 1 bit each: depth==0 and depth==DEPTH respectively.
REQ-014 The module SHALL have ports o_OVERFLOW and o_UNDERFLOW, outputs, 1 bit each: one-cycle pulses marking a rejected operation.
REQ-015 The module SHALL have port o_ERROR, output, 1 bit: sticky OR of all overflow and underflow events.

Function
REQ-016 The opcodes SHALL be: 000 NOP, 001 PUSH, 010 POP, 011 REPL (overwrite TOS), 100 POPREPL (drop TOS, then overwrite the new TOS; this is the binary-ALU result), 101 POP2 (drop two entries), 110/111 treated as NOP.
REQ-017 Each accepted operation SHALL take effect at the clock edge that samples it, and o_OP1, o_OP2 and o_DEPTH SHALL show the result from the next cycle onward (latency 1).
REQ-018 o_OP1 and o_OP2 SHALL be driven directly from registers, with no combinational path from i_OP or i_DATA.
REQ-019 Any element position at or above the current depth SHALL read as 0 on o_OP1, o_OP2 and o_PICK.
REQ-020 PUSH SHALL behave as follows: NOS is spilled to the array, TOS moves to NOS, i_DATA becomes TOS, and depth is incremented.
REQ-021 POP SHALL behave as follows: NOS moves to TOS, the array top refills NOS, and depth is decremented.
REQ-022 POP2 SHALL behave as follows: array top moves to TOS, the next array entry moves to NOS, and depth is reduced by 2.
REQ-023 REPL SHALL set TOS to i_DATA and leave depth unchanged.
REQ-024 POPREPL SHALL set TOS to i_DATA, refill NOS from the array top, and reduce depth by 1.
REQ-025 PUSH at depth==DEPTH SHALL be rejected: no state change, o_OVERFLOW=1 for one cycle, and o_ERROR is set.
REQ-026 POP or REPL at depth 0, and POPREPL or POP2 at depth <2, SHALL be rejected: no state change, o_UNDERFLOW=1 for one cycle, and o_ERROR is set.
REQ-027 o_ERROR SHALL remain set until reset and SHALL NOT block later valid operations.
REQ-028 The pick read SHALL sample i_PICK every cycle and present the element on o_PICK one cycle later, using the pre-operation stack contents of the sampling cycle; it SHALL be independent of i_OP.
REQ-029 A pick index >= depth SHALL return 0.
REQ-030 Depth arithmetic SHALL use PTR_W+1 bits and SHALL never wrap; it is guarded solely by REQ-025 and REQ-026.
REQ-031 o_FULL and o_EMPTY SHALL be derived from registered depth and SHALL be mutually exclusive.

Reset
REQ-032 When f_RESET=1 at a rising edge, the module SHALL clear depth, o_OP1, o_OP2, o_PICK, o_OVERFLOW, o_UNDERFLOW and o_ERROR to 0, and o_EMPTY SHALL read 1 and o_FULL 0.
REQ-033 Reset SHALL take priority over any simultaneous i_OP, and an operation presented in the reset cycle SHALL be discarded.
REQ-034 Array contents SHALL NOT be cleared by reset; correctness relies solely on the depth masking in REQ-019.

Structure
REQ-035 The opcode localparams and the PTR_W derivation helper SHALL live in the shared package stack_pkg.
REQ-036 The array SHALL be one sub-module, stack_ram: DEPTH-2 entries, one synchronous write port, one combinational read port for refill, and one read port for pick.
REQ-037 TOS and NOS SHALL be registers in param_stack, not array entries.

Verification
REQ-038 Reset then 3 PUSHes of 0x0011, 0x0022, 0x0033 SHALL give o_OP1=0x0033, o_OP2=0x0022 and o_DEPTH=3 one cycle after the last push.
REQ-039 With stack [0x33,0x22,0x11], POPREPL with i_DATA=0x0055 SHALL give TOS=0x0055, NOS=0x0011, depth=2; then POP2 SHALL give depth=0, o_OP1=0, o_OP2=0 and o_EMPTY=1.
REQ-040 Filling the stack with DEPTH PUSHes then issuing 1 more PUSH SHALL produce o_OVERFLOW for one cycle, o_ERROR=1, depth unchanged at DEPTH and TOS unchanged; a following POP SHALL succeed.
REQ-041 POP at depth 0 and POP2 at depth 1 SHALL each produce an o_UNDERFLOW pulse with no state change.
REQ-042 With stack [0x33,0x22,0x11], i_PICK=2 SHALL give o_PICK=0x0011 one cycle later, and i_PICK=3 SHALL give 0; a PUSH issued in the same cycle SHALL NOT alter that pick result.
REQ-043 f_RESET asserted in the same cycle as a PUSH at depth 5 SHALL give depth=0, all outputs 0 and the push discarded.
